// File: rtl/shift16_tx_ctrl.sv
// -----------------------------------------------------------------------------
// shift16_tx_ctrl
//
// Sequencing controller for a WIDTH-bit right-shift register. It accepts one
// parallel word over a valid/ready handshake, loads it into the shift
// register, then paces the shifting at DIV clocks per bit. Bits come out
// LSB-first on SerOut, with a one-cycle SerStrobe at the start of every bit
// period.
//
// Optional feature macro: SHIFT16_TX_PARITY_EN
//   When defined, one extra bit period follows the data. It carries the
//   even-parity bit (the XOR of all transmitted data bits) and does not shift
//   the register.
//
// Parameters
//   WIDTH  shift-register width (TxData, SrData, bit counter sizing)
//   DIV    clock cycles per bit period, >= 1
//   FILL   constant driven on SrShiftIn
//
// Ports
//   Clock       in   sole clock, rising edge
//   Aclr        in   asynchronous active-low reset
//   TxValid     in   word offered
//   TxData      in   word to send
//   TxLen       in   number of bits to send; 0 or > WIDTH means WIDTH
//   TxReady     out  controller can accept a word (decoded from state)
//   SrData      out  shift-register parallel data
//   SrLoad      out  shift-register load
//   SrEnable    out  shift-register enable (load or shift right)
//   SrShiftIn   out  shift-register serial input, always FILL
//   SrShiftOut  in   shift-register Q(0)
//   SerOut      out  serial bit, held for a whole bit period
//   SerStrobe   out  one-cycle pulse on the first cycle of each bit period
//   Busy        out  high in every state except IDLE (decoded from state)
//   Done        out  one-cycle pulse when a word completes
// -----------------------------------------------------------------------------
module shift16_tx_ctrl #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIV   = 4,
  parameter logic        FILL  = 1'b0
) (
  input  logic                       Clock,
  input  logic                       Aclr,
  input  logic                       TxValid,
  input  logic [WIDTH-1:0]           TxData,
  input  logic [$clog2(WIDTH+1)-1:0] TxLen,
  output logic                       TxReady,
  output logic [WIDTH-1:0]           SrData,
  output logic                       SrLoad,
  output logic                       SrEnable,
  output logic                       SrShiftIn,
  input  logic                       SrShiftOut,
  output logic                       SerOut,
  output logic                       SerStrobe,
  output logic                       Busy,
  output logic                       Done
);

  localparam int unsigned   CW       = $clog2(WIDTH + 1);
  localparam int unsigned   DW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LEN_MAX  = CW'(WIDTH);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic          DIV_ONE  = (DIV == 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
`ifdef SHIFT16_TX_PARITY_EN
    ST_PARITY,
`endif
    ST_DONE
  } state_e;

  state_e          state_q;
  logic [WIDTH-1:0] srdata_q;
  logic [WIDTH-1:0] mirror_q;    // tracks what the shift register will hold
  logic [CW-1:0]    cnt_q;       // bits still to send
  logic [DW-1:0]    div_q;       // cycles left in the current bit period
  logic             srload_q;
  logic             srenable_q;
  logic             serout_q;
  logic             serstrobe_q;
  logic             done_q;
  logic [CW-1:0]    len_norm;

  // Zero and oversize lengths both mean a full word.
  always_comb begin
    // NOTE: default assignment first so every path drives len_norm and no latch is inferred.
    len_norm = TxLen;
    if ((TxLen == '0) || (TxLen > LEN_MAX)) begin
      len_norm = LEN_MAX;
    end
  end

`ifdef SHIFT16_TX_PARITY_EN
  logic par_q;
  logic par_now;
  // The register's Q(0) is the current bit during the strobe cycle, so the
  // running parity folds it in there.
  assign par_now = par_q ^ (serstrobe_q & SrShiftOut);
`endif

  // The shift register only presents a new Q(0) after the same edge that
  // raises SerStrobe, so a registered SerOut cannot take that bit from the
  // pin in time. The bit is presented from mirror_q at the period start and
  // then re-sampled from SrShiftOut in the strobe cycle.
  // NOTE: non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge Clock or negedge Aclr) begin
    if (!Aclr) begin
      state_q     <= ST_IDLE;
      srdata_q    <= '0;
      mirror_q    <= '0;
      cnt_q       <= '0;
      div_q       <= '0;
      srload_q    <= 1'b0;
      srenable_q  <= 1'b0;
      serout_q    <= 1'b0;
      serstrobe_q <= 1'b0;
      done_q      <= 1'b0;
`ifdef SHIFT16_TX_PARITY_EN
      par_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (TxValid) begin
            state_q    <= ST_LOAD;
            srdata_q   <= TxData;
            mirror_q   <= TxData;
            cnt_q      <= len_norm;
            srload_q   <= 1'b1;
            srenable_q <= 1'b1;
`ifdef SHIFT16_TX_PARITY_EN
            par_q      <= 1'b0;
`endif
          end
        end

        ST_LOAD: begin
          state_q     <= ST_SHIFT;
          srload_q    <= 1'b0;
          div_q       <= DIV_LAST;
          srenable_q  <= DIV_ONE;
          serstrobe_q <= 1'b1;
          serout_q    <= mirror_q[0];
        end

        ST_SHIFT: begin
`ifdef SHIFT16_TX_PARITY_EN
          par_q <= par_now;
`endif
          if (div_q == '0) begin
            // Last cycle of the period: the register shifts on this edge.
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
              srenable_q <= 1'b0;
`ifdef SHIFT16_TX_PARITY_EN
              state_q     <= ST_PARITY;
              div_q       <= DIV_LAST;
              serstrobe_q <= 1'b1;
              serout_q    <= par_now;
`else
              state_q     <= ST_DONE;
              done_q      <= 1'b1;
              serstrobe_q <= 1'b0;
              serout_q    <= 1'b0;
`endif
            end else begin
              div_q       <= DIV_LAST;
              srenable_q  <= DIV_ONE;
              serstrobe_q <= 1'b1;
              serout_q    <= mirror_q[1];
              mirror_q    <= mirror_q >> 1;
            end
          end else begin
            div_q       <= div_q - DW'(1);
            srenable_q  <= (div_q == DW'(1));
            serstrobe_q <= 1'b0;
            if (serstrobe_q) begin
              serout_q <= SrShiftOut;
            end
          end
        end

`ifdef SHIFT16_TX_PARITY_EN
        ST_PARITY: begin
          serstrobe_q <= 1'b0;
          if (div_q == '0) begin
            state_q  <= ST_DONE;
            done_q   <= 1'b1;
            serout_q <= 1'b0;
          end else begin
            div_q <= div_q - DW'(1);
          end
        end
`endif

        ST_DONE: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign TxReady   = (state_q == ST_IDLE);
  assign Busy      = (state_q != ST_IDLE);
  assign SrData    = srdata_q;
  assign SrLoad    = srload_q;
  assign SrEnable  = srenable_q;
  assign SrShiftIn = FILL;
  assign SerOut    = serout_q;
  assign SerStrobe = serstrobe_q;
  assign Done      = done_q;

endmodule

// File: tb/tb_shift16_tx_ctrl.sv
// -----------------------------------------------------------------------------
// tb_shift16_tx_ctrl
//
// Bench for shift16_tx_ctrl (WIDTH=16, DIV=4). It models the attached 16-bit
// shift register, keeps a per-transaction timeline model of the expected
// outputs and compares against it on every falling edge. Directed scenarios
// pin waveform details to hand-computed values. Follows
// SHIFT16_TX_PARITY_EN when defined.
// -----------------------------------------------------------------------------
module tb_shift16_tx_ctrl;

  localparam int WIDTH = 16;
  localparam int DIV   = 4;
`ifdef SHIFT16_TX_PARITY_EN
  localparam int PAR_EXTRA = 1;
`else
  localparam int PAR_EXTRA = 0;
`endif

  logic        Clock   = 1'b0;
  logic        Aclr    = 1'b1;
  logic        TxValid = 1'b0;
  logic [15:0] TxData  = '0;
  logic [4:0]  TxLen   = '0;
  logic        TxReady, SrLoad, SrEnable, SrShiftIn, SerOut, SerStrobe, Busy, Done;
  logic [15:0] SrData;
  logic [15:0] sr_q = '0;   // the shift register this controller drives

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  shift16_tx_ctrl #(.WIDTH(WIDTH), .DIV(DIV), .FILL(1'b0)) dut (
    .Clock      (Clock),
    .Aclr       (Aclr),
    .TxValid    (TxValid),
    .TxData     (TxData),
    .TxLen      (TxLen),
    .TxReady    (TxReady),
    .SrData     (SrData),
    .SrLoad     (SrLoad),
    .SrEnable   (SrEnable),
    .SrShiftIn  (SrShiftIn),
    .SrShiftOut (sr_q[0]),
    .SerOut     (SerOut),
    .SerStrobe  (SerStrobe),
    .Busy       (Busy),
    .Done       (Done)
  );

  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  // Right-shift register: Load has priority, Enable alone shifts ShiftIn in.
  always @(posedge Clock) begin
    if (SrLoad)        sr_q <= SrData;
    else if (SrEnable) sr_q <= {SrShiftIn, sr_q[15:1]};
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int norm_len(input logic [4:0] l);
    return ((l == 5'd0) || (l > 5'd16)) ? 16 : int'(l);
  endfunction

  function automatic logic parity_of(input logic [15:0] d, input int n);
    logic p;
    p = 1'b0;
    for (int i = 0; i < n; i++) p ^= d[i];
    return p;
  endfunction

  // ---------------------------------------------------------------------------
  // Timeline model: m_t counts edges since acceptance, so the current cycle
  // is c = m_t + 1 (LOAD is cycle 1). A word of N bits occupies cycles
  // 1 .. 2 + (N + parity) * DIV.
  // ---------------------------------------------------------------------------
  logic        m_active = 1'b0;
  int          m_t      = 0;
  int          m_n      = 16;
  logic [15:0] m_data   = '0;
  logic [15:0] m_srdata = '0;

  always @(posedge Clock or negedge Aclr) begin
    if (!Aclr) begin
      m_active <= 1'b0;
      m_t      <= 0;
      m_srdata <= '0;
    end else if (!m_active) begin
      if (TxValid) begin
        m_active <= 1'b1;
        m_t      <= 0;
        m_n      <= norm_len(TxLen);
        m_data   <= TxData;
        m_srdata <= TxData;
      end
    end else if (m_t + 1 >= 2 + (m_n + PAR_EXTRA) * DIV) begin
      m_active <= 1'b0;
    end else begin
      m_t <= m_t + 1;
    end
  end

  task automatic compare_cycle();
    int   c, p, d, k;
    logic e_load, e_en, e_stb, e_ser, e_done;
    c = m_t + 1;
    p = m_n + PAR_EXTRA;
    d = 2 + p * DIV;
    e_load = 1'b0; e_en = 1'b0; e_stb = 1'b0; e_ser = 1'b0; e_done = 1'b0;
    if (m_active) begin
      e_load = (c == 1);
      e_en   = (c == 1) || (((c - 1) % DIV == 0) && ((c - 1) / DIV >= 1) && ((c - 1) / DIV <= m_n));
      e_stb  = (c >= 2) && ((c - 2) % DIV == 0) && ((c - 2) / DIV < p);
      e_done = (c == d);
      if (c >= 2 && c < d) begin
        k = (c - 2) / DIV;
        if (k < m_n)       e_ser = m_data[k];
        else if (k == m_n) e_ser = parity_of(m_data, m_n);
      end
    end
    check("cmp_TxReady",   32'(TxReady),   32'(!m_active));
    check("cmp_Busy",      32'(Busy),      32'(m_active));
    check("cmp_SrLoad",    32'(SrLoad),    32'(e_load));
    check("cmp_SrEnable",  32'(SrEnable),  32'(e_en));
    check("cmp_SerStrobe", 32'(SerStrobe), 32'(e_stb));
    check("cmp_SerOut",    32'(SerOut),    32'(e_ser));
    check("cmp_Done",      32'(Done),      32'(e_done));
    check("cmp_SrData",    32'(SrData),    32'(m_srdata));
    check("cmp_SrShiftIn", 32'(SrShiftIn), 32'd0);
  endtask

  initial forever begin
    @(negedge Clock);
    compare_cycle();
  end

  // ---------------------------------------------------------------------------
  // Capture monitor for the directed scenarios; cycle numbers are relative to
  // the acceptance edge (mon_acc).
  // ---------------------------------------------------------------------------
  logic mon_on  = 1'b0;
  int   mon_acc = 0;
  int   mon_en  = 0;
  int   mon_ready = -1;
  logic mon_bits[$];
  int   mon_loads[$];
  int   mon_dones[$];

  task automatic mon_start(input int acc);
    mon_acc   = acc;
    mon_en    = 0;
    mon_ready = -1;
    mon_bits.delete();
    mon_loads.delete();
    mon_dones.delete();
    mon_on    = 1'b1;
  endtask

  task automatic monitor_cycle();
    int rel;
    rel = cyc - mon_acc + 1;
    if (SerStrobe)           mon_bits.push_back(SerOut);
    if (SrEnable && !SrLoad) mon_en++;
    if (SrLoad)              mon_loads.push_back(rel);
    if (Done)                mon_dones.push_back(rel);
    if (TxReady && mon_ready < 0 && mon_dones.size() > 0) mon_ready = rel;
  endtask

  initial forever begin
    @(negedge Clock);
    if (mon_on) monitor_cycle();
  end

  function automatic logic [31:0] packed_bits();
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < mon_bits.size() && i < 32; i++) v[i] = mon_bits[i];
    return v;
  endfunction

  function automatic int first_or_neg(input int q[$], input int idx);
    return (q.size() > idx) ? q[idx] : -1;
  endfunction

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Offer one word for exactly one cycle, then scramble the inputs.
  task automatic start_word(input logic [15:0] d, input logic [4:0] len);
    TxValid = 1'b1;
    TxData  = d;
    TxLen   = len;
    mon_start(cyc + 1);
    tick();
    TxValid = 1'b0;
    TxData  = 16'hDEAD;
    TxLen   = 5'd7;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (mon_ready < 0 && n < budget) begin
      tick();
      n++;
    end
    check("ready_within_budget", 32'(mon_ready >= 0), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, rel;
    #1 Aclr = 1'b0;
    repeat (2) @(posedge Clock);
    #3 Aclr = 1'b1;
    tick();

    // Reset state
    check("rst_TxReady",  32'(TxReady),  32'd1);
    check("rst_Busy",     32'(Busy),     32'd0);
    check("rst_SrData",   32'(SrData),   32'd0);
    check("rst_SrLoad",   32'(SrLoad),   32'd0);
    check("rst_SrEnable", 32'(SrEnable), 32'd0);
    check("rst_SerOut",   32'(SerOut),   32'd0);
    check("rst_Done",     32'(Done),     32'd0);

    // Full word: bits 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1 == A5C3 LSB-first
    start_word(16'hA5C3, 5'd16);
    wait_done(100);
    check("w16_nbits",  32'(mon_bits.size()), 32'd16);
    check("w16_bits",   packed_bits(), 32'h0000A5C3);
    check("w16_shifts", 32'(mon_en), 32'd16);
    check("w16_done",   32'(first_or_neg(mon_dones, 0)), 32'(2 + 16 * DIV + PAR_EXTRA * DIV));
    check("w16_ready",  32'(mon_ready), 32'(3 + 16 * DIV + PAR_EXTRA * DIV));
`ifndef SHIFT16_TX_PARITY_EN
    check("w16_done_lit",  32'(first_or_neg(mon_dones, 0)), 32'd66);
    check("w16_ready_lit", 32'(mon_ready), 32'd67);
`endif

    // TxLen=0 behaves as 16
    start_word(16'hA5C3, 5'd0);
    wait_done(100);
    check("w0_nbits", 32'(mon_bits.size()), 32'd16);
    check("w0_bits",  packed_bits(), 32'h0000A5C3);
    check("w0_done",  32'(first_or_neg(mon_dones, 0)), 32'(2 + 16 * DIV + PAR_EXTRA * DIV));

    // TxLen>16 clamps to 16
    start_word(16'h3C5A, 5'd20);
    wait_done(100);
    check("w20_nbits", 32'(mon_bits.size()), 32'd16);
    check("w20_bits",  packed_bits(), 32'h00003C5A);

    // Short word: 3 strobes 1,0,1 and 3 shifts
    start_word(16'h0005, 5'd3);
    wait_done(40);
    check("w3_nbits",  32'(mon_bits.size()), 32'(3 + PAR_EXTRA));
    check("w3_bits",   packed_bits() & 32'h7, 32'h5);
    check("w3_shifts", 32'(mon_en), 32'd3);
`ifndef SHIFT16_TX_PARITY_EN
    check("w3_done", 32'(first_or_neg(mon_dones, 0)), 32'd14);
`endif

    // Single-bit word
    start_word(16'hFFFE, 5'd1);
    wait_done(20);
    check("w1_bits0", 32'(mon_bits.size() > 0 ? mon_bits[0] : 1'bx), 32'd0);
    check("w1_shifts", 32'(mon_en), 32'd1);

    // TxValid held high; only the word present in each ready cycle goes out
    TxValid = 1'b1;
    TxLen   = 5'd2;
    TxData  = 16'h0003;
    acc     = cyc + 1;
    mon_start(acc);
    for (int i = 0; i < 40; i++) begin
      tick();
      rel = cyc - acc + 1;
      if (rel < 11)       TxData = 16'h0000;
      else if (rel == 11) TxData = 16'h0002;
      else                TxData = 16'h0001;
      if (rel >= 22) TxValid = 1'b0;
      if (rel >= 26) break;
    end
    check("hold_nbits", 32'(mon_bits.size()), 32'(4 + 2 * PAR_EXTRA));
`ifndef SHIFT16_TX_PARITY_EN
    check("hold_bits",  packed_bits(), 32'hB);
    check("hold_load2", 32'(first_or_neg(mon_loads, 1)), 32'd12);
    check("hold_done1", 32'(first_or_neg(mon_dones, 0)), 32'd10);
    check("hold_done2", 32'(first_or_neg(mon_dones, 1)), 32'd21);
    check("hold_nloads", 32'(mon_loads.size()), 32'd2);
`endif

    // Reset in the middle of SHIFT, during the second shift pulse (cycle 9)
    start_word(16'hA5C3, 5'd16);
    repeat (8) tick();
    check("pre_rst_SrEnable", 32'(SrEnable), 32'd1);
    check("pre_rst_Busy",     32'(Busy),     32'd1);
    #2 Aclr = 1'b0;
    #1;
    mon_on = 1'b0;
    check("mid_rst_SrEnable",  32'(SrEnable),  32'd0);
    check("mid_rst_SerStrobe", 32'(SerStrobe), 32'd0);
    check("mid_rst_Busy",      32'(Busy),      32'd0);
    check("mid_rst_Done",      32'(Done),      32'd0);
    check("mid_rst_TxReady",   32'(TxReady),   32'd1);
    check("mid_rst_SrData",    32'(SrData),    32'd0);
    repeat (2) @(posedge Clock);
    #3 Aclr = 1'b1;
    tick();
    start_word(16'h0005, 5'd3);
    wait_done(40);
    check("post_rst_bits",   packed_bits() & 32'h7, 32'h5);
    check("post_rst_shifts", 32'(mon_en), 32'd3);

    // Parity word (parity bit = 1 when the feature is built in)
    start_word(16'h0007, 5'd4);
    wait_done(60);
    check("par_shifts", 32'(mon_en), 32'd4);
`ifdef SHIFT16_TX_PARITY_EN
    check("par_nbits", 32'(mon_bits.size()), 32'd5);
    check("par_bits",  packed_bits(), 32'h17);
    check("par_done",  32'(first_or_neg(mon_dones, 0)), 32'd22);
`else
    check("par_nbits", 32'(mon_bits.size()), 32'd4);
    check("par_bits",  packed_bits(), 32'h7);
    check("par_done",  32'(first_or_neg(mon_dones, 0)), 32'd18);
`endif

    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/shift16_tx_ctrl.md
# shift16_tx_ctrl

Sequencing controller for the 16-bit right-shift register (`Data`/`Load`/`Enable`/`ShiftIn`/`ShiftOut`). It accepts a parallel word over a valid/ready handshake, loads it into the shift register and paces shifting at a programmable bit period. It presents the serial stream LSB-first on `SerOut` with a per-bit strobe. The controller sits between the word producer and the shift-register instance and is the only driver of that register's control pins.

## Interface
- `WIDTH`, 16: shift-register width; `TxLen` and the bit counter are sized to it.
- `DIV`, 4: clock cycles per bit period, ≥1.
- `FILL`, 1'b0: constant driven on `SrShiftIn`.

- `Clock`  in  1  sole clock, rising edge.
- `Aclr`  in  1  asynchronous, active-low reset.
- `TxValid`  in  1  word offered.
- `TxData`  in  16  word to send.
- `TxLen`  in  5  bits to send, 1..16; 0 is treated as 16, and values >16 are clamped to 16.
- `TxReady`  out  1  controller can accept a word.
- `SrData`  out  16  drives shift-register `Data`.
- `SrLoad`  out  1  drives `Load`.
- `SrEnable`  out  1  drives `Enable`.
- `SrShiftIn`  out  1  drives `ShiftIn`, always `FILL`.
- `SrShiftOut`  in  1  from `ShiftOut` (current Q(0)).
- `SerOut`  out  1  serial bit, held for a full bit period.
- `SerStrobe`  out  1  one-cycle pulse on the first cycle of each bit period.
- `Busy`  out  1  high in every state except IDLE.
- `Done`  out  1  one-cycle pulse when a word completes.

## Operation
- States: IDLE, LOAD, SHIFT, PARITY (only with the macro), DONE.
- IDLE: `TxReady`=1. When `TxValid`&&`TxReady` is sampled, the controller captures `TxData` into the `SrData` register and the normalised `TxLen` into the bit counter, then moves to LOAD.
- LOAD: one cycle with `SrLoad`=1 and `SrEnable`=1. Next state is SHIFT.
- SHIFT: a divider counts DIV−1..0.
  - On the first cycle of each period: `SerOut`←`SrShiftOut`, `SerStrobe`=1.
  - On the last cycle of each period: `SrEnable`=1 for one cycle, which shifts the register right, and the bit counter decrements.
  - When the counter reaches 0 at the end of a period, the next state is PARITY (macro on) or DONE.
- DONE: one cycle, `Done`=1, `SerOut`←0. Next state is IDLE.
- `TxValid` is ignored whenever `TxReady`=0. `TxData` and `TxLen` only need to be stable in the acceptance cycle.
- `SrLoad` and `SrEnable` are never high together except in LOAD.
- Reset (`Aclr`=0) mid-operation forces IDLE immediately, with all outputs at their reset values. The shift-register contents are not cleared by this block.
- Reset values: `TxReady`=1, `SrData`=0, `SrLoad`=0, `SrEnable`=0, `SerOut`=0, `SerStrobe`=0, `Busy`=0, `Done`=0, bit counter=0, divider=0.

## Timing
- Call the acceptance edge cycle 0. LOAD is cycle 1; the shift register's Q is valid after the cycle-1 edge.
- First `SerStrobe` is in cycle 2. Bit k (0-based) is strobed in cycle 2+k·DIV.
- `SrEnable` pulses occur in cycles 1+(k+1)·DIV.
- Without the macro, `Done` is in cycle 2+N·DIV and `TxReady` returns to 1 in cycle 3+N·DIV. A new word can be accepted in that cycle.
- With the macro, `Done` is in cycle 2+(N+1)·DIV.
- All outputs are registered except `TxReady` and `Busy`, which decode state directly.

## Configuration
- `SHIFT16_TX_PARITY_EN` defined:
  - The PARITY state is compiled in and lasts one bit period.
  - `SerOut` carries the even-parity bit, the XOR of all N transmitted bits accumulated at each strobe.
  - `SerStrobe` pulses on its first cycle. `SrEnable` stays 0 throughout.
- Not defined: PARITY state, parity accumulator and the extra period are absent, and SHIFT goes straight to DONE.

## Test plan
- Reset, DIV=4, send `TxData`=16'hA5C3, `TxLen`=16 → `SerOut` at the 16 strobes is 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1. `Done` in cycle 66; `TxReady` returns high in cycle 67.
- `TxLen`=0 vs `TxLen`=16, same data → identical waveforms.
- `TxLen`=3, `TxData`=16'h0005 → 3 strobes (1,0,1), exactly 3 `SrEnable` pulses after LOAD, `Done` in cycle 14.
- `TxValid` held high throughout with changing `TxData` → only the word present in the ready cycle is sent. The next word is accepted in the cycle `TxReady` re-asserts, with no idle gap.
- `Aclr` low mid-SHIFT → `SrEnable`, `SerStrobe`, `Busy` and `Done` drop to 0 immediately and `TxReady`=1. After release a fresh word transmits normally.
- Macro on, `TxData`=16'h0007, `TxLen`=4 → data strobes 1,1,1,0, then a 5th strobe with `SerOut`=1. No 5th `SrEnable` pulse. `Done` in cycle 22.
